amba3_axi_sram_slave: RTL and testbench

Synthesizable AMBA 3 AXI slave backed by an internal word-organised SRAM array. It is the RTL endpoint downstream of the AXI master-side bus functional model, and it consumes the five AXI3 channels directly. It supports FIXED, INCR and WRAP bursts of 1–16 beats and byte strobes, with one outstanding write and one outstanding read. The write and read paths run concurrently and independently.

---
 rtl/amba3_axi_sram_slave.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_amba3_axi_sram_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amba3_axi_sram_slave.sv
// AMBA 3 AXI slave in front of an internal word-organised SRAM.
// Supports one outstanding write and one outstanding read.
// The write and read paths run independently.
// Supported bursts are FIXED, INCR and WRAP, each of 1-16 beats, with byte strobes.
// Optional feature macro: AMBA3_AXI_SRAM_DECERR_EN.
//   When defined, beats addressed beyond the array are dropped and answered with DECERR.
//   When undefined, addresses alias modulo the memory size.
module amba3_axi_sram_slave #(
    parameter int TXID_SIZE = 4,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic [TXID_SIZE-1:0]   awid,
    input  logic [ADDR_SIZE-1:0]   awaddr,
    input  logic [3:0]             awlen,
    input  logic [2:0]             awsize,
    input  logic [1:0]             awburst,
    input  logic [1:0]             awlock,
    input  logic [3:0]             awcache,
    input  logic [2:0]             awprot,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [TXID_SIZE-1:0]   wid,
    input  logic [DATA_SIZE-1:0]   wdata,
    input  logic [DATA_SIZE/8-1:0] wstrb,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [TXID_SIZE-1:0]   bid,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [TXID_SIZE-1:0]   arid,
    input  logic [ADDR_SIZE-1:0]   araddr,
    input  logic [3:0]             arlen,
    input  logic [2:0]             arsize,
    input  logic [1:0]             arburst,
    input  logic [1:0]             arlock,
    input  logic [3:0]             arcache,
    input  logic [2:0]             arprot,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [TXID_SIZE-1:0]   rid,
    output logic [DATA_SIZE-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic                   rvalid,
    input  logic                   rready
);

    localparam int STRB_SIZE = DATA_SIZE / 8;
    localparam int LANE_W    = $clog2(STRB_SIZE);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [2:0]           MAX_SIZE = 3'(LANE_W);
    localparam logic [ADDR_SIZE-1:0] ONE      = ADDR_SIZE'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

    // Lock, cache and prot carry no meaning for a plain SRAM.
    logic unused_sideband;
    assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot};

    // Beats wider than the bus are treated as full-width beats.
    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > MAX_SIZE) ? MAX_SIZE : s;
    endfunction

    // Address of the following beat.
    // A WRAP burst with an illegal length falls back to INCR.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] addr,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst,
                                                       input logic [3:0] len);
        logic [ADDR_SIZE-1:0] step, incr, wrap_mask;
        step      = ONE << size;
        incr      = (addr & ~(step - ONE)) + step;
        wrap_mask = ((ADDR_SIZE'(len) + ONE) << size) - ONE;
        if (burst == 2'b00)
            return addr;
        if (burst == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
            return (addr & ~wrap_mask) | (incr & wrap_mask);
        return incr;
    endfunction

    // ---------------- write path ----------------
    w_state_t             w_state;
    logic [TXID_SIZE-1:0] w_id;
    logic [ADDR_SIZE-1:0] w_addr, w_next;
    logic [3:0]           w_len, w_cnt;
    logic [2:0]           w_size;
    logic [1:0]           w_burst, w_resp;
    logic                 w_slverr_q, w_slverr_now, w_beat, w_final, w_in_range;
    logic [IDX_W-1:0]     w_idx;

    assign w_next       = next_addr(w_addr, w_size, w_burst, w_len);
    assign w_idx        = w_addr[LANE_W +: IDX_W];
    assign w_beat       = wvalid && wready;
    assign w_final      = (w_cnt == w_len) || wlast;
    assign w_slverr_now = w_slverr_q || (wid != w_id) || (wlast != (w_cnt == w_len));

`ifdef AMBA3_AXI_SRAM_DECERR_EN
    logic w_decerr_q, w_decerr_now;
    assign w_in_range   = (w_addr[ADDR_SIZE-1:LANE_W+IDX_W] == '0);
    assign w_decerr_now = w_decerr_q || !w_in_range;

    // Decode errors outrank protocol errors in the burst response.
    always_comb begin
        w_resp = 2'b00;
        if (w_decerr_now)      w_resp = 2'b11;
        else if (w_slverr_now) w_resp = 2'b10;
    end

    // Remember whether any beat of the current burst fell outside the array.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n)                                   w_decerr_q <= 1'b0;
        else if (w_state == W_IDLE && awvalid && awready) w_decerr_q <= 1'b0;
        else if (w_beat)                                 w_decerr_q <= w_decerr_now;
    end
`else
    assign w_in_range = 1'b1;

    // Protocol errors are the only possible write failure when addresses alias.
    always_comb begin
        w_resp = 2'b00;
        if (w_slverr_now) w_resp = 2'b10;
    end
`endif

    // Write FSM: accept the address, then stream the beats, then return the response.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state    <= W_IDLE;
            w_id       <= '0;
            w_addr     <= '0;
            w_len      <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            w_cnt      <= '0;
            w_slverr_q <= 1'b0;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bid        <= '0;
            bresp      <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_id       <= awid;
                        w_addr     <= awaddr;
                        w_len      <= awlen;
                        w_size     <= clamp_size(awsize);
                        w_burst    <= awburst;
                        w_cnt      <= '0;
                        w_slverr_q <= 1'b0;
                        awready    <= 1'b0;
                        wready     <= 1'b1;
                        w_state    <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_addr     <= w_next;
                        w_cnt      <= w_cnt + 4'd1;
                        w_slverr_q <= w_slverr_now;
                        if (w_final) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= w_resp;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Commit the strobed byte lanes of every accepted, in-range write beat.
    always_ff @(posedge aclk) begin
        if (w_beat && w_in_range) begin
            for (int i = 0; i < STRB_SIZE; i++) begin
                if (wstrb[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t             r_state;
    logic [ADDR_SIZE-1:0] r_addr, r_next;
    logic [3:0]           r_len, r_cnt;
    logic [2:0]           r_size;
    logic [1:0]           r_burst, r_resp_next;
    logic [IDX_W-1:0]     r_fetch_idx;
    logic [DATA_SIZE-1:0] r_word;

    assign r_next      = next_addr(r_addr, r_size, r_burst, r_len);
    assign r_fetch_idx = (r_state == R_IDLE) ? araddr[LANE_W +: IDX_W] : r_next[LANE_W +: IDX_W];

`ifdef AMBA3_AXI_SRAM_DECERR_EN
    logic r_fetch_ok;
    assign r_fetch_ok  = (r_state == R_IDLE) ? (araddr[ADDR_SIZE-1:LANE_W+IDX_W] == '0)
                                             : (r_next[ADDR_SIZE-1:LANE_W+IDX_W] == '0);
    assign r_word      = r_fetch_ok ? mem[r_fetch_idx] : '0;
    assign r_resp_next = r_fetch_ok ? 2'b00 : 2'b11;
`else
    assign r_word      = mem[r_fetch_idx];
    assign r_resp_next = 2'b00;
`endif

    // Read FSM: fetch a word on the AR handshake and on every accepted beat.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rid     <= arid;
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= clamp_size(arsize);
                        r_burst <= arburst;
                        r_cnt   <= '0;
                        rdata   <= r_word;
                        rresp   <= r_resp_next;
                        rlast   <= (arlen == 4'd0);
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_next;
                            r_cnt  <= r_cnt + 4'd1;
                            rdata  <= r_word;
                            rresp  <= r_resp_next;
                            rlast  <= ((r_cnt + 4'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amba3_axi_sram_slave.sv
// Directed self-checking bench for amba3_axi_sram_slave.
// Expected values are hand-computed constants.
// The out-of-range test follows the AMBA3_AXI_SRAM_DECERR_EN build option.
module tb_amba3_axi_sram_slave;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic        aclk, areset_n;
    logic [3:0]  awid, wid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, wstrb, awcache, arcache;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    amba3_axi_sram_slave dut (
        .aclk(aclk), .areset_n(areset_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [31:0] wData [16];
    logic [3:0]  wStrb [16];
    logic [31:0] rData [16];
    logic        rLastQ [16];
    logic [1:0]  rRespQ [16];
    logic [3:0]  rIdQ [16];
    int          rBeats;
    logic [1:0]  bRespV;
    logic [3:0]  bIdV;

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic sendAw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        bit ok = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge aclk);
            if (awready) ok = 1;
            tick();
        end
        awvalid = 1'b0;
        if (!ok) checkOutput("aw_timeout", 0, 1);
    endtask

    task automatic sendW(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit ok = 0;
        wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge aclk);
            if (wready) ok = 1;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (!ok) checkOutput("w_timeout", 0, 1);
    endtask

    // Full write transaction from wData/wStrb.
    // lastAt is the beat carrying wlast (-1 means none); badIdAt is the beat sent with a wrong wid.
    task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int lastAt, input int badIdAt);
        int  nBeats;
        bit  ok = 0;
        nBeats = (lastAt >= 0 && lastAt < int'(len)) ? lastAt + 1 : int'(len) + 1;
        sendAw(id, addr, len, size, burst);
        for (int b = 0; b < nBeats; b++)
            sendW((b == badIdAt) ? (id ^ 4'h1) : id, wData[b], wStrb[b], b == lastAt);
        bready = 1'b1;
        bRespV = 2'bxx; bIdV = 4'hx;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge aclk);
            if (bvalid) begin ok = 1; bRespV = bresp; bIdV = bid; end
            tick();
        end
        bready = 1'b0;
        if (!ok) checkOutput("b_timeout", 0, 1);
    endtask

    // Full read transaction, optionally toggling rready, checking hold-while-stalled.
    task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        bit          ok = 0, done = 0, stalled = 0;
        logic [63:0] held = '0;
        rready = 1'b1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge aclk);
            if (arready) ok = 1;
            tick();
        end
        arvalid = 1'b0;
        if (!ok) checkOutput("ar_timeout", 0, 1);
        checkOutput("r_latency", 64'(rvalid), 1);
        rBeats = 0;
        for (int c = 0; c < 100 && !done && rBeats < 16; c++) begin
            @(negedge aclk);
            if (rvalid) begin
                if (stalled) checkOutput("r_stable", {27'd0, rlast, rid, rdata}, held);
                if (rready) begin
                    rData[rBeats] = rdata; rLastQ[rBeats] = rlast;
                    rRespQ[rBeats] = rresp; rIdQ[rBeats] = rid;
                    rBeats++;
                    stalled = 0;
                    if (rlast) done = 1;
                end else begin
                    held = {27'd0, rlast, rid, rdata};
                    stalled = 1;
                end
            end
            tick();
            if (toggle) rready = ~rready;
        end
        rready = 1'b0;
        if (!done) checkOutput("r_timeout", 0, 1);
    endtask

    // Directed scenario list.
    task automatic applyStimulus();
        // reset values
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("reset_ready", {awready, wready, arready}, 0);
        checkOutput("reset_valid", {bvalid, rvalid, rlast}, 0);
        checkOutput("reset_rdata", rdata, 0);
        checkOutput("reset_resp_id", {bresp, rresp, bid, rid}, 0);
        @(negedge aclk);
        areset_n = 1'b1;
        tick();
        checkOutput("ready_after_reset", {awready, arready}, 2'b11);

        // W beats ahead of AW are refused
        wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        tick();
        checkOutput("w_before_aw_0", 64'(wready), 0);
        tick();
        checkOutput("w_before_aw_1", 64'(wready), 0);
        wvalid = 1'b0;

        // single write then read
        wData[0] = 32'hDEAD_BEEF; wStrb[0] = 4'hF;
        writeBurst(4'd5, 32'h10, 4'd0, 3'd2, INCR, 0, -1);
        checkOutput("single_bresp", bRespV, 2'b00);
        checkOutput("single_bid", bIdV, 4'd5);
        readBurst(4'd5, 32'h10, 4'd0, 3'd2, INCR, 0);
        checkOutput("single_beats", rBeats, 1);
        checkOutput("single_rdata", rData[0], 32'hDEAD_BEEF);
        checkOutput("single_rlast", rLastQ[0], 1);
        checkOutput("single_rid", rIdQ[0], 4'd5);
        checkOutput("single_rresp", rRespQ[0], 2'b00);

        // strobe merge
        wData[0] = 32'h1122_3344; wStrb[0] = 4'hF;
        writeBurst(4'd1, 32'h20, 4'd0, 3'd2, INCR, 0, -1);
        wData[0] = 32'hAABB_CCDD; wStrb[0] = 4'h5;
        writeBurst(4'd1, 32'h20, 4'd0, 3'd2, INCR, 0, -1);
        checkOutput("strobe_bresp", bRespV, 2'b00);
        readBurst(4'd1, 32'h20, 4'd0, 3'd2, INCR, 0);
        checkOutput("strobe_rdata", rData[0], 32'h11BB_33DD);

        // WRAP len=3 from 0x38 lands at 38, 3C, 30, 34
        for (int i = 0; i < 4; i++) begin wData[i] = 32'(i + 1); wStrb[i] = 4'hF; end
        writeBurst(4'd2, 32'h38, 4'd3, 3'd2, WRAP, 3, -1);
        checkOutput("wrap_bresp", bRespV, 2'b00);
        readBurst(4'd2, 32'h30, 4'd3, 3'd2, INCR, 0);
        checkOutput("wrap_beats", rBeats, 4);
        checkOutput("wrap_r0", rData[0], 3);
        checkOutput("wrap_r1", rData[1], 4);
        checkOutput("wrap_r2", rData[2], 1);
        checkOutput("wrap_r3", rData[3], 2);

        // 16-beat read with rready toggling every cycle
        for (int i = 0; i < 16; i++) begin
            wData[i] = 32'h1020_3040 + 32'(i) * 32'h0101_0101; wStrb[i] = 4'hF;
        end
        writeBurst(4'd3, 32'h100, 4'd15, 3'd2, INCR, 15, -1);
        checkOutput("bp_bresp", bRespV, 2'b00);
        readBurst(4'd9, 32'h100, 4'd15, 3'd2, INCR, 1);
        checkOutput("bp_beats", rBeats, 16);
        for (int i = 0; i < 16; i++) begin
            checkOutput("bp_data", rData[i], 32'h1020_3040 + 32'(i) * 32'h0101_0101);
            checkOutput("bp_rlast", rLastQ[i], (i == 15) ? 1 : 0);
        end
        checkOutput("bp_rid", rIdQ[15], 4'd9);

        // protocol errors
        for (int i = 0; i < 4; i++) begin wData[i] = 32'hE0 + 32'(i); wStrb[i] = 4'hF; end
        writeBurst(4'd4, 32'h80, 4'd3, 3'd2, INCR, 1, -1);
        checkOutput("early_wlast_bresp", bRespV, 2'b10);
        writeBurst(4'd4, 32'h80, 4'd0, 3'd2, INCR, 0, 0);
        checkOutput("bad_wid_bresp", bRespV, 2'b10);
        checkOutput("bad_wid_bid", bIdV, 4'd4);
        writeBurst(4'd4, 32'h80, 4'd1, 3'd2, INCR, -1, -1);
        checkOutput("no_wlast_bresp", bRespV, 2'b10);

        // FIXED burst keeps hitting one word
        wData[0] = 32'hA; wData[1] = 32'hB; wData[2] = 32'hC;
        for (int i = 0; i < 3; i++) wStrb[i] = 4'hF;
        writeBurst(4'd6, 32'h40, 4'd2, 3'd2, FIXED, 2, -1);
        readBurst(4'd6, 32'h40, 4'd1, 3'd2, FIXED, 0);
        checkOutput("fixed_r0", rData[0], 32'hC);
        checkOutput("fixed_r1", rData[1], 32'hC);

        // oversize beat clamps to a 4-byte step
        wData[0] = 32'h5555_AAAA; wData[1] = 32'h1234_5678;
        writeBurst(4'd6, 32'h50, 4'd1, 3'd5, INCR, 1, -1);
        readBurst(4'd6, 32'h50, 4'd1, 3'd2, INCR, 0);
        checkOutput("clamp_r0", rData[0], 32'h5555_AAAA);
        checkOutput("clamp_r1", rData[1], 32'h1234_5678);

        // beyond the array
        wData[0] = 32'h0BAD_F00D; wStrb[0] = 4'hF;
        writeBurst(4'd8, 32'h0, 4'd0, 3'd2, INCR, 0, -1);
`ifdef AMBA3_AXI_SRAM_DECERR_EN
        wData[0] = 32'hFFFF_FFFF;
        writeBurst(4'd8, 32'h1000, 4'd0, 3'd2, INCR, 0, -1);
        checkOutput("oor_bresp", bRespV, 2'b11);
        readBurst(4'd8, 32'h0, 4'd0, 3'd2, INCR, 0);
        checkOutput("oor_mem_intact", rData[0], 32'h0BAD_F00D);
        readBurst(4'd8, 32'h1000, 4'd0, 3'd2, INCR, 0);
        checkOutput("oor_rdata", rData[0], 0);
        checkOutput("oor_rresp", rRespQ[0], 2'b11);
`else
        wData[0] = 32'h600D_CAFE;
        writeBurst(4'd8, 32'h1000, 4'd0, 3'd2, INCR, 0, -1);
        checkOutput("alias_bresp", bRespV, 2'b00);
        readBurst(4'd8, 32'h0, 4'd0, 3'd2, INCR, 0);
        checkOutput("alias_rdata", rData[0], 32'h600D_CAFE);
        checkOutput("alias_rresp", rRespQ[0], 2'b00);
`endif

        // reset in the middle of a write burst
        sendAw(4'd7, 32'h200, 4'd3, 3'd2, INCR);
        sendW(4'd7, 32'h1111_0000, 4'hF, 1'b0);
        sendW(4'd7, 32'h2222_0000, 4'hF, 1'b0);
        areset_n = 1'b0;
        #2;
        checkOutput("midreset_outputs", {awready, wready, bvalid}, 0);
        tick();
        @(negedge aclk);
        areset_n = 1'b1;
        tick();
        checkOutput("midreset_awready", 64'(awready), 1);
        checkOutput("midreset_no_b", 64'(bvalid), 0);
        readBurst(4'd7, 32'h200, 4'd1, 3'd2, INCR, 0);
        checkOutput("midreset_r0", rData[0], 32'h1111_0000);
        checkOutput("midreset_r1", rData[1], 32'h2222_0000);
    endtask

    initial begin
        areset_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        awlock = '0; awcache = '0; awprot = '0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        arlock = '0; arcache = '0; arprot = '0; rready = 1'b0;
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a hung handshake outside the bounded loops.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
